// File: rtl/ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package ctrl_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Stall vector bit order: {WB, MEM/WB, EX/MEM, ID/EX, IF/ID, PC}
  localparam logic [5:0] STALL_NONE = {6{NOSTOP}};
  localparam logic [5:0] STALL_ID   = {NOSTOP, NOSTOP, NOSTOP, STOP, STOP, STOP};
  localparam logic [5:0] STALL_EX   = {NOSTOP, NOSTOP, STOP, STOP, STOP, STOP};
  localparam logic [5:0] STALL_MEM  = {NOSTOP, STOP, STOP, STOP, STOP, STOP};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EX_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam int unsigned MEM_TIMEOUT_DEF = 16;
  localparam logic [31:0] BUSERR_VEC_DEF  = 32'h0000_0040;
  localparam logic [31:0] PC_NONE         = '0;

endpackage

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: arbitrates ID/EX/MEM hazards and exceptions,
// tracks multi-cycle EX occupancy and times out stuck data-bus accesses.
module pipeline_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter logic [31:0] BUSERR_VEC  = BUSERR_VEC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        ex_start,
  input  logic [3:0]  ex_cycles,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        excp_valid,
  input  logic [31:0] excp_vec,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        ex_done,
  output logic        bus_err
);

  localparam logic [7:0] MEM_LOAD = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ex_cnt_q, ex_cnt_d;
  logic       ex_done_q, ex_done_d;

  logic       mem_wait;
  logic       timeout;
  logic       flush_req;
  logic [7:0] ex_rem;

  // ex_rem: EX hold cycles still owed, counting the current cycle.
  always_comb begin
    mem_wait  = mem_req & ~mem_ack;
    // Expiry on the MEM_TIMEOUT-th wait cycle, i.e. when this decrement would reach zero.
    timeout   = (state_q == MEM_WAIT) && mem_wait && (cnt_q == 8'd1);
    flush_req = excp_valid | timeout;
    case (state_q)
      EX_BUSY:  ex_rem = cnt_q;
      MEM_WAIT: ex_rem = ex_cnt_q;
      default:  ex_rem = ex_start ? {4'b0000, ex_cycles} : '0;
    endcase
  end

  always_comb begin
    stall   = STALL_NONE;
    flush   = 1'b0;
    new_pc  = PC_NONE;
    bus_err = 1'b0;
    if (rst) begin
      if (flush_req) begin
        flush   = 1'b1;
        bus_err = timeout;
        new_pc  = excp_valid ? excp_vec : BUSERR_VEC;
      end else if (mem_wait) begin
        stall = STALL_MEM;
      end else if (ex_rem != '0) begin
        stall = STALL_EX;
      end else if (stallreq_id) begin
        stall = STALL_ID;
      end
    end
  end

  // EX counting continues in ex_cnt while MEM_WAIT owns the shared counter.
  always_comb begin
    state_d   = IDLE;
    cnt_d     = '0;
    ex_cnt_d  = '0;
    ex_done_d = 1'b0;
    if (!flush_req) begin
      ex_done_d = (ex_rem == 8'd1);
      if (mem_wait) begin
        state_d  = MEM_WAIT;
        cnt_d    = (state_q == MEM_WAIT) ? cnt_q - 8'd1 : MEM_LOAD;
        ex_cnt_d = (ex_rem != '0) ? ex_rem - 8'd1 : '0;
      end else if (ex_rem > 8'd1) begin
        state_d = EX_BUSY;
        cnt_d   = ex_rem - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ex_cnt_q  <= '0;
      ex_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ex_cnt_q  <= ex_cnt_d;
      ex_done_q <= ex_done_d;
    end
  end

  assign ex_done = ex_done_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: cycle-level reference model plus
// directed scenarios with hand-computed literal expectations.
module tb_pipeline_ctrl;

  localparam int unsigned TMO  = 16;
  localparam logic [31:0] BVEC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        ex_start = 1'b0;
  logic [3:0]  ex_cycles = '0;
  logic        mem_req = 1'b0;
  logic        mem_ack = 1'b0;
  logic        excp_valid = 1'b0;
  logic [31:0] excp_vec = '0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_done;
  logic        bus_err;

  pipeline_ctrl #(.MEM_TIMEOUT(TMO), .BUSERR_VEC(BVEC)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_start(ex_start),
    .ex_cycles(ex_cycles), .mem_req(mem_req), .mem_ack(mem_ack),
    .excp_valid(excp_valid), .excp_vec(excp_vec), .stall(stall),
    .flush(flush), .new_pc(new_pc), .ex_done(ex_done), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: hold cycles still owed, consecutive wait cycles seen, pending done pulse.
  int   m_ex_rem = 0;
  int   m_wait   = 0;
  logic m_done   = 1'b0;

  function automatic void model_out(output logic [5:0] e_stall, output logic e_flush,
                                    output logic [31:0] e_pc, output logic e_berr,
                                    output int hold_now, output int wait_n);
    logic waiting, tmo;
    if (m_ex_rem > 0) hold_now = m_ex_rem;
    else if (m_wait == 0 && ex_start) hold_now = int'(ex_cycles);
    else hold_now = 0;
    waiting = mem_req && !mem_ack;
    wait_n  = waiting ? m_wait + 1 : 0;
    tmo     = waiting && (wait_n >= int'(TMO));
    e_flush = excp_valid || tmo;
    e_berr  = tmo;
    e_pc    = e_flush ? (excp_valid ? excp_vec : BVEC) : 32'h0;
    if (e_flush)          e_stall = 6'b000000;
    else if (waiting)     e_stall = 6'b011111;
    else if (hold_now > 0) e_stall = 6'b001111;
    else if (stallreq_id) e_stall = 6'b000111;
    else                  e_stall = 6'b000000;
    if (!rst) begin
      e_stall = '0; e_flush = 1'b0; e_pc = '0; e_berr = 1'b0;
    end
  endfunction

  always @(posedge clk or negedge rst) begin : model_upd
    logic [5:0] s; logic f; logic [31:0] p; logic b; int h; int w;
    if (!rst) begin
      m_ex_rem <= 0; m_wait <= 0; m_done <= 1'b0;
    end else begin
      model_out(s, f, p, b, h, w);
      if (f) begin
        m_ex_rem <= 0; m_wait <= 0; m_done <= 1'b0;
      end else begin
        m_done   <= (h == 1);
        m_ex_rem <= (h > 0) ? h - 1 : 0;
        m_wait   <= w;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [5:0] s; logic f; logic [31:0] p; logic b; int h; int w;
    model_out(s, f, p, b, h, w);
    chk("stall", {26'b0, stall}, {26'b0, s});
    chk("flush", {31'b0, flush}, {31'b0, f});
    chk("new_pc", new_pc, p);
    chk("bus_err", {31'b0, bus_err}, {31'b0, b});
    chk("ex_done", {31'b0, ex_done}, {31'b0, (rst ? m_done : 1'b0)});
  end

  task automatic tick(input logic sid, input logic es, input logic [3:0] ec, input logic mr,
                      input logic ma, input logic ev, input logic [31:0] vec);
    @(posedge clk);
    #1;
    stallreq_id = sid; ex_start = es; ex_cycles = ec;
    mem_req = mr; mem_ack = ma; excp_valid = ev; excp_vec = vec;
    #2;
  endtask

  task automatic idle();
    tick(0, 0, 4'd0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    #2;
    chk("rst_stall", {26'b0, stall}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_ex_done", {31'b0, ex_done}, 32'h0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
    #10 rst = 1'b1;

    // Load-use
    tick(1, 0, 4'd0, 0, 0, 0, 32'h0);
    chk("ld_use_stall", {26'b0, stall}, 32'h07);
    chk("ld_use_flush", {31'b0, flush}, 32'h0);
    idle();
    chk("ld_use_release", {26'b0, stall}, 32'h0);

    // Divider, 5 cycles
    tick(0, 1, 4'd5, 0, 0, 0, 32'h0);
    chk("div_c1", {26'b0, stall}, 32'h0f);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("div_hold", {26'b0, stall}, 32'h0f);
    end
    idle();
    chk("div_c6_stall", {26'b0, stall}, 32'h0);
    chk("div_c6_done", {31'b0, ex_done}, 32'h1);
    idle();
    chk("div_done_once", {31'b0, ex_done}, 32'h0);

    // Zero- and one-cycle EX ops
    tick(0, 1, 4'd0, 0, 0, 0, 32'h0);
    chk("ex0_stall", {26'b0, stall}, 32'h0);
    idle();
    chk("ex0_no_done", {31'b0, ex_done}, 32'h0);
    tick(0, 1, 4'd1, 0, 0, 0, 32'h0);
    chk("ex1_stall", {26'b0, stall}, 32'h0f);
    idle();
    chk("ex1_done", {31'b0, ex_done}, 32'h1);

    // Bus wait acked after 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 4'd0, 1, 0, 0, 32'h0);
      chk("bus_wait", {26'b0, stall}, 32'h1f);
    end
    tick(0, 0, 4'd0, 1, 1, 0, 32'h0);
    chk("bus_ack", {26'b0, stall}, 32'h0);
    idle();

    // Timeout on the 16th wait cycle
    for (int i = 0; i < 15; i++) tick(0, 0, 4'd0, 1, 0, 0, 32'h0);
    chk("pre_tmo_flush", {31'b0, flush}, 32'h0);
    tick(0, 0, 4'd0, 1, 0, 0, 32'h0);
    chk("tmo_flush", {31'b0, flush}, 32'h1);
    chk("tmo_pc", new_pc, 32'h40);
    chk("tmo_buserr", {31'b0, bus_err}, 32'h1);
    chk("tmo_stall", {26'b0, stall}, 32'h0);
    idle();
    chk("tmo_after", {31'b0, flush}, 32'h0);

    // Ack on the expiry cycle wins
    for (int i = 0; i < 15; i++) tick(0, 0, 4'd0, 1, 0, 0, 32'h0);
    tick(0, 0, 4'd0, 1, 1, 0, 32'h0);
    chk("ack_wins_flush", {31'b0, flush}, 32'h0);
    chk("ack_wins_berr", {31'b0, bus_err}, 32'h0);
    idle();

    // Exception together with timeout
    for (int i = 0; i < 15; i++) tick(0, 0, 4'd0, 1, 0, 0, 32'h0);
    tick(0, 0, 4'd0, 1, 0, 1, 32'h0000_0200);
    chk("excp_tmo_pc", new_pc, 32'h200);
    chk("excp_tmo_berr", {31'b0, bus_err}, 32'h1);
    idle();

    // MEM wait of 2 cycles inside a 6-cycle EX hold
    tick(0, 1, 4'd6, 0, 0, 0, 32'h0);
    chk("ovl_c0", {26'b0, stall}, 32'h0f);
    idle();
    chk("ovl_c1", {26'b0, stall}, 32'h0f);
    tick(0, 0, 4'd0, 1, 0, 0, 32'h0);
    chk("ovl_c2", {26'b0, stall}, 32'h1f);
    tick(0, 0, 4'd0, 1, 0, 0, 32'h0);
    chk("ovl_c3", {26'b0, stall}, 32'h1f);
    tick(0, 0, 4'd0, 1, 1, 0, 32'h0);
    chk("ovl_c4", {26'b0, stall}, 32'h0f);
    idle();
    chk("ovl_c5", {26'b0, stall}, 32'h0f);
    idle();
    chk("ovl_c6_stall", {26'b0, stall}, 32'h0);
    chk("ovl_c6_done", {31'b0, ex_done}, 32'h1);

    // Exception in 3rd cycle of a 5-cycle hold
    tick(0, 1, 4'd5, 0, 0, 0, 32'h0);
    idle();
    tick(0, 0, 4'd0, 0, 0, 1, 32'h0000_0180);
    chk("xmid_flush", {31'b0, flush}, 32'h1);
    chk("xmid_pc", new_pc, 32'h180);
    chk("xmid_stall", {26'b0, stall}, 32'h0);
    idle();
    chk("xmid_idle", {26'b0, stall}, 32'h0);
    chk("xmid_no_done", {31'b0, ex_done}, 32'h0);
    repeat (4) begin
      idle();
      chk("xmid_quiet", {31'b0, ex_done}, 32'h0);
    end

    // Async reset mid EX_BUSY
    tick(0, 1, 4'd4, 0, 0, 0, 32'h0);
    idle();
    chk("ar_before", {26'b0, stall}, 32'h0f);
    #1 rst = 1'b0;
    #1;
    chk("ar_stall", {26'b0, stall}, 32'h0);
    chk("ar_flush", {31'b0, flush}, 32'h0);
    chk("ar_pc", new_pc, 32'h0);
    chk("ar_done", {31'b0, ex_done}, 32'h0);
    chk("ar_berr", {31'b0, bus_err}, 32'h0);
    @(posedge clk);
    #3 rst = 1'b1;
    tick(0, 1, 4'd2, 0, 0, 0, 32'h0);
    chk("ar_ex2_c0", {26'b0, stall}, 32'h0f);
    idle();
    chk("ar_ex2_c1", {26'b0, stall}, 32'h0f);
    idle();
    chk("ar_ex2_c2", {26'b0, stall}, 32'h0);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
